interrupt_controller: RTL and testbench
=======================================

# interrupt_controller

Upstream companion of the CPU core. Collects eight peripheral request lines, edge-detects and latches them as pending, applies a software mask, and presents one prioritised request plus a 16-bit handler vector to the CPU. It tracks the in-service interrupt through an acknowledge/done handshake. Mask and pending state are memory-mapped on the CPU data/address bus.

## Interface
- `BASE_ADDR`, default 16'hFF00: base of the 3-word register window.
- `VECTOR_BASE`, default 16'h0010: vector of source 0. Source n maps to VECTOR_BASE + 2·n.
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: asynchronous, active-high. One clock; reset is asynchronous and active-high.
- `irq_lines` in 8: peripheral requests, synchronous to `clk`. A rising edge is a request.
- `address_bus` in 16: CPU address.
- `data_bus` inout 16: CPU data. Driven by this block only for a decoded read.
- `r` in 1: CPU read strobe.
- `w` in 1: CPU write strobe. Asserted in the clk-low phase only.
- `irq` out 1: interrupt request to the CPU.
- `irq_vector` out 16: handler address. Valid while `irq`=1.
- `irq_ack` in 1: one-cycle pulse. CPU has taken the request.
- `irq_done` in 1: one-cycle pulse. CPU has finished the handler.

## Operation
- Register map, word addresses:
  - BASE+0 PENDING: reads pending[7:0] zero-extended. Write-1-to-clear, bits [7:0].
  - BASE+1 MASK: read/write. Bits [7:0] enable; bits 15:8 read 0.
  - BASE+2 STATUS: read-only. {busy, 4'b0, idx[2:0]} in bits [7:0]. busy = state≠IDLE.
- Edge detect:
  - `prev` holds `irq_lines` from the previous cycle.
  - `rise = irq_lines & ~prev` sets pending bits.
- Priority: lowest set index of `pending & mask` wins. Bit 0 is highest priority.
- FSM states IDLE, REQUEST, SERVICE:
  - **IDLE:** if `pending & mask` ≠ 0, latch winner into `idx` and go to REQUEST.
  - **REQUEST:**
    - `irq`=1; `irq_vector` = VECTOR_BASE + {idx,1'b0}.
    - `irq_ack` → clear pending[idx], go to SERVICE.
    - If pending[idx] or mask[idx] is cleared before ack, return to IDLE without ack. A different source may then win.
    - A higher-priority arrival does not preempt the latched `idx`.
  - **SERVICE:** `irq`=0. `irq_done` → IDLE. No nesting: new requests stay pending.
  - `irq_ack` outside REQUEST and `irq_done` outside SERVICE are ignored.
- Simultaneous events on the same bit in one cycle: set (rise) beats clear (W1C or ack clear). The request re-pends.
- Width rules: vector addition wraps modulo 2^16. Writes ignore data bits 15:8.
- Reset mid-operation:
  - Clears pending, mask, prev (to 0), idx.
  - FSM → IDLE, `irq`=0.
  - A line held high through reset produces no request until it falls and rises again.

## Timing
- Reset values: `irq`=0, `irq_vector`=VECTOR_BASE, `data_bus`=Z, pending=0, mask=0.
- Request latency: edge on `irq_lines` seen at rising edge k → pending at k, FSM in REQUEST at k+1. `irq` and vector are registered, high after k+1. Two cycles from edge to `irq`.
- Ack: `irq_ack` sampled at edge j → `irq`=0 after j and pending[idx] cleared at j.
- Done: `irq_done` at edge j → IDLE after j. A next pending request raises `irq` after j+1.
- Read: combinational. `data_bus` is driven while `r`=1 and the address hits the window, otherwise Z. The CPU samples at the falling edge.
- Write: `w` is high in the low phase; address and data are stable over the whole cycle. The write commits at the rising edge ending that low phase.
- Mask change: takes effect in the arbitration on the edge after the write commits.

## Structure
- Shared package/include: register offsets (PENDING=0, MASK=1, STATUS=2), FSM state encodings, source count 8.
- One sub-module, `priority_encoder8`: 8-bit input → 3-bit index + valid. Purely combinational.

## Test plan
- **Reset then single source:** mask=8'h01; pulse irq_lines[0].
  - Expect `irq`=1 two cycles later, `irq_vector`=16'h0010.
  - ack → `irq`=0, PENDING reads 0.
  - done → STATUS busy=0.
- **Priority:** mask=8'hFF; rise on lines 5 and 2 in the same cycle.
  - Expect vector 16'h0014.
  - After ack/done, expect vector 16'h001A.
- **Masking:** mask=0; rise on line 3 → PENDING reads 16'h0008, `irq` stays 0. Write mask=8'h08 → `irq` rises.
- **Cancel in REQUEST:** line 1 requesting. Write 16'h0002 to PENDING before ack → `irq` drops, FSM IDLE, no vector asserted afterwards.
- **Collision:** same-cycle rise on line 4 and `irq_ack` for idx 4 → pending[4] remains 1, re-requested after done.
- **Async reset mid-SERVICE:** with line 6 held high, assert `reset` → all outputs at reset values immediately. Line 6 stays high → no `irq` until it toggles low then high.

Source files
------------

// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: register offsets,
// source count and FSM state encodings.
package interrupt_controller_pkg;

    localparam int NUM_SRC = 8;

    localparam logic [1:0] REG_PENDING = 2'd0;
    localparam logic [1:0] REG_MASK    = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

endpackage

// File: rtl/interrupt_controller_priority_encoder8.sv
// Combinational 8-to-3 priority encoder: the lowest set bit wins.
module priority_encoder8
    import interrupt_controller_pkg::*;
(
    input  logic [7:0] req_i,
    output logic [2:0] idx_o,
    output logic       valid_o
);

    always_comb begin
        idx_o   = 3'd0;
        valid_o = |req_i;
        // Walk downwards so the lowest set index is the last to assign.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = 3'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Eight-source edge-triggered interrupt controller with masking, a single
// prioritised request to the CPU, and an ack/done in-service handshake.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = 16'hFF00,
    parameter logic [15:0] VECTOR_BASE = 16'h0010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  irq_lines,
    input  logic [15:0] address_bus,
    inout  wire  [15:0] data_bus,
    input  logic        r,
    input  logic        w,
    output logic        irq,
    output logic [15:0] irq_vector,
    input  logic        irq_ack,
    input  logic        irq_done
);

    logic [7:0]  pending_q, pending_d;
    logic [7:0]  mask_q, mask_d;
    logic [7:0]  prev_q;
    logic        armed_q;
    state_t      state_q;
    logic [2:0]  idx_q;
    logic        irq_q;
    logic [15:0] irq_vector_q;

    logic [15:0] offset;
    logic        hit;
    logic [1:0]  reg_sel;
    logic [7:0]  wdata;
    logic        unused_wdata_hi;
    logic [7:0]  rise, ack_clr, w1c_clr, active;
    logic [2:0]  win_idx;
    logic        win_valid;
    logic [15:0] rdata;

    assign offset          = address_bus - BASE_ADDR;
    assign hit             = offset < 16'd3;
    assign reg_sel         = offset[1:0];
    assign wdata           = data_bus[7:0];
    assign unused_wdata_hi = ^data_bus[15:8];

    // armed_q blocks edge detection on the first edge after reset so a line
    // held high through reset is not mistaken for a fresh request.
    assign rise      = armed_q ? (irq_lines & ~prev_q) : 8'h00;
    assign ack_clr   = (state_q == ST_REQUEST && irq_ack) ? (8'h01 << idx_q) : 8'h00;
    assign w1c_clr   = (w && hit && reg_sel == REG_PENDING) ? wdata : 8'h00;
    assign pending_d = (pending_q & ~(ack_clr | w1c_clr)) | rise;
    assign mask_d    = (w && hit && reg_sel == REG_MASK) ? wdata : mask_q;
    assign active    = pending_q & mask_q;

    priority_encoder8 u_prio (
        .req_i   (active),
        .idx_o   (win_idx),
        .valid_o (win_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= 8'h00;
            mask_q    <= 8'h00;
            prev_q    <= 8'h00;
            armed_q   <= 1'b0;
        end else begin
            pending_q <= pending_d;
            mask_q    <= mask_d;
            prev_q    <= irq_lines;
            armed_q   <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= 3'd0;
            irq_q        <= 1'b0;
            irq_vector_q <= VECTOR_BASE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (win_valid) begin
                        state_q      <= ST_REQUEST;
                        idx_q        <= win_idx;
                        irq_q        <= 1'b1;
                        irq_vector_q <= VECTOR_BASE + {12'h000, win_idx, 1'b0};
                    end
                end
                ST_REQUEST: begin
                    if (irq_ack) begin
                        state_q <= ST_SERVICE;
                        irq_q   <= 1'b0;
                    end else if (!active[idx_q]) begin
                        state_q <= ST_IDLE;
                        irq_q   <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (irq_done) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    irq_q   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rdata = 16'h0000;
        case (reg_sel)
            REG_PENDING: rdata = {8'h00, pending_q};
            REG_MASK:    rdata = {8'h00, mask_q};
            REG_STATUS:  rdata = {8'h00, state_q != ST_IDLE, 4'b0000, idx_q};
            default:     rdata = 16'h0000;
        endcase
    end

    assign data_bus   = (r && hit) ? rdata : 16'hzzzz;
    assign irq        = irq_q;
    assign irq_vector = irq_vector_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: an abstract cycle model checked on
// every falling edge plus literal expectations taken from the test plan.
module tb_interrupt_controller;

    localparam logic [15:0] BASE = 16'hFF00;
    localparam logic [15:0] VB   = 16'h0010;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  irq_lines = 8'h00;
    logic [15:0] address_bus = 16'h0000;
    logic        r = 1'b0;
    logic        w = 1'b0;
    logic        irq;
    logic [15:0] irq_vector;
    logic        irq_ack = 1'b0;
    logic        irq_done = 1'b0;
    logic [15:0] tb_data = 16'h0000;
    logic        tb_drive = 1'b0;
    wire  [15:0] data_bus;

    int total = 0;
    int bad = 0;
    logic [15:0] exp_q[$];

    assign data_bus = tb_drive ? tb_data : 16'hzzzz;

    interrupt_controller #(
        .BASE_ADDR   (BASE),
        .VECTOR_BASE (VB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .irq_lines   (irq_lines),
        .address_bus (address_bus),
        .data_bus    (data_bus),
        .r           (r),
        .w           (w),
        .irq         (irq),
        .irq_vector  (irq_vector),
        .irq_ack     (irq_ack),
        .irq_done    (irq_done)
    );

    // Clock and reset
    always #5 clk = ~clk;

    // Behavioural model: which source is being offered, which is in service.
    bit [7:0] m_pend = 8'h00;
    bit [7:0] m_mask = 8'h00;
    bit [7:0] m_prev = 8'h00;
    bit       m_armed = 1'b0;
    bit       m_req = 1'b0;
    bit       m_svc = 1'b0;
    int       m_cur = 0;
    int       m_win;
    int       m_clr;

    function automatic int lowest(input bit [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pend = 8'h00; m_mask = 8'h00; m_prev = 8'h00;
            m_armed = 1'b0; m_req = 1'b0; m_svc = 1'b0; m_cur = 0;
        end else begin
            m_clr = -1;
            if (m_req) begin
                if (irq_ack) begin
                    m_req = 1'b0; m_svc = 1'b1; m_clr = m_cur;
                end else if (!(m_pend[m_cur] && m_mask[m_cur])) begin
                    m_req = 1'b0;
                end
            end else if (m_svc) begin
                if (irq_done) m_svc = 1'b0;
            end else begin
                m_win = lowest(m_pend & m_mask);
                if (m_win >= 0) begin
                    m_req = 1'b1; m_cur = m_win;
                end
            end
            if (w && address_bus == BASE) m_pend = m_pend & ~tb_data[7:0];
            if (m_clr >= 0) m_pend[m_clr] = 1'b0;
            if (m_armed) m_pend = m_pend | (irq_lines & ~m_prev);
            if (w && address_bus == BASE + 16'd1) m_mask = tb_data[7:0];
            m_prev  = irq_lines;
            m_armed = 1'b1;
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (reset) begin
            check("rst_irq", {15'b0, irq}, 16'h0000);
            check("rst_vec", irq_vector, VB);
        end else begin
            check("model_irq", {15'b0, irq}, {15'b0, m_req});
            if (m_req) check("model_vec", irq_vector, VB + 16'(2 * m_cur));
        end
    end

    // Driver tasks
    task automatic wr(input logic [1:0] off, input logic [15:0] data);
        @(negedge clk);
        address_bus = BASE + 16'(off);
        tb_data = data;
        tb_drive = 1'b1;
        w = 1'b1;
        @(posedge clk);
        #1;
        w = 1'b0;
        tb_drive = 1'b0;
    endtask

    task automatic rd(input logic [1:0] off, output logic [15:0] val);
        address_bus = BASE + 16'(off);
        r = 1'b1;
        #1;
        val = data_bus;
        r = 1'b0;
    endtask

    task automatic rd_lit(input logic [1:0] off, input logic [15:0] exp, input string name);
        logic [15:0] v;
        rd(off, v);
        check(name, v, exp);
    endtask

    task automatic rd_model(input logic [1:0] off, input string name);
        logic [15:0] v;
        case (off)
            2'd0:    exp_q.push_back({8'h00, m_pend});
            2'd1:    exp_q.push_back({8'h00, m_mask});
            default: exp_q.push_back({8'h00, m_req | m_svc, 4'b0000, 3'(m_cur)});
        endcase
        rd(off, v);
        check(name, v, exp_q.pop_front());
    endtask

    task automatic set_lines(input logic [7:0] v);
        @(negedge clk);
        irq_lines = v;
    endtask

    task automatic pulse_ack();
        @(negedge clk); irq_ack = 1'b1;
        @(negedge clk); irq_ack = 1'b0;
    endtask

    task automatic pulse_done();
        @(negedge clk); irq_done = 1'b1;
        @(negedge clk); irq_done = 1'b0;
    endtask

    task automatic wait_irq(input logic lvl, input int budget, input string name);
        int n = 0;
        while (irq !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {15'b0, irq}, {15'b0, lvl});
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state and stray handshakes
        rd_lit(2'd0, 16'h0000, "reset_pending");
        rd_lit(2'd1, 16'h0000, "reset_mask");
        rd_lit(2'd2, 16'h0000, "reset_status");
        pulse_ack();
        pulse_done();
        rd_lit(2'd2, 16'h0000, "stray_ack_done");

        // Single source, two-cycle latency
        wr(2'd1, 16'hFF01);
        rd_lit(2'd1, 16'h0001, "mask_hi_ignored");
        set_lines(8'h01);
        @(negedge clk);
        check("lat_one_cycle", {15'b0, irq}, 16'h0000);
        @(negedge clk);
        check("lat_two_cycle", {15'b0, irq}, 16'h0001);
        check("vec_src0", irq_vector, 16'h0010);
        set_lines(8'h00);
        pulse_ack();
        check("ack_drops_irq", {15'b0, irq}, 16'h0000);
        rd_lit(2'd0, 16'h0000, "ack_clears_pending");
        rd_lit(2'd2, 16'h0080, "service_busy");
        pulse_done();
        rd_lit(2'd2, 16'h0000, "done_idle");

        // Priority between two simultaneous sources
        wr(2'd1, 16'h00FF);
        set_lines(8'h24);
        @(negedge clk);
        @(negedge clk);
        check("prio_irq", {15'b0, irq}, 16'h0001);
        check("prio_vec_first", irq_vector, 16'h0014);
        set_lines(8'h00);
        pulse_ack();
        rd_model(2'd0, "prio_pending_model");
        pulse_done();
        wait_irq(1'b1, 4, "prio_second_irq");
        check("prio_vec_second", irq_vector, 16'h001A);
        pulse_ack();
        pulse_done();

        // Masked source stays pending until enabled
        wr(2'd1, 16'h0000);
        set_lines(8'h08);
        set_lines(8'h00);
        repeat (2) @(negedge clk);
        check("masked_no_irq", {15'b0, irq}, 16'h0000);
        rd_lit(2'd0, 16'h0008, "masked_pending");
        wr(2'd1, 16'h0008);
        wait_irq(1'b1, 4, "unmask_irq");
        check("unmask_vec", irq_vector, 16'h0016);
        pulse_ack();
        pulse_done();

        // Cancel by W1C while requesting
        wr(2'd1, 16'h0002);
        set_lines(8'h02);
        wait_irq(1'b1, 5, "cancel_irq_up");
        check("cancel_vec", irq_vector, 16'h0012);
        set_lines(8'h00);
        wr(2'd0, 16'h0002);
        wait_irq(1'b0, 3, "cancel_drop");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("cancel_quiet", {15'b0, irq}, 16'h0000);
        end
        rd_lit(2'd2, 16'h0001, "cancel_status");

        // Rise and ack on the same bit in one cycle
        wr(2'd1, 16'h0010);
        set_lines(8'h10);
        wait_irq(1'b1, 5, "coll_irq_up");
        check("coll_vec", irq_vector, 16'h0018);
        set_lines(8'h00);
        @(negedge clk);
        irq_lines = 8'h10;
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        check("coll_irq_low", {15'b0, irq}, 16'h0000);
        rd_lit(2'd0, 16'h0010, "coll_repended");
        rd_lit(2'd2, 16'h0084, "coll_status");
        pulse_done();
        wait_irq(1'b1, 4, "coll_rerequest");
        check("coll_vec_again", irq_vector, 16'h0018);
        pulse_ack();
        set_lines(8'h00);
        pulse_done();

        // Async reset during service with the line held high
        wr(2'd1, 16'h0040);
        set_lines(8'h40);
        wait_irq(1'b1, 5, "arst_irq_up");
        pulse_ack();
        #2;
        reset = 1'b1;
        #1;
        check("arst_irq", {15'b0, irq}, 16'h0000);
        check("arst_vec", irq_vector, 16'h0010);
        rd_lit(2'd2, 16'h0000, "arst_status");
        rd_lit(2'd1, 16'h0000, "arst_mask");
        @(negedge clk);
        reset = 1'b0;
        wr(2'd1, 16'h0040);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("held_no_irq", {15'b0, irq}, 16'h0000);
        end
        rd_lit(2'd0, 16'h0000, "held_no_pending");
        set_lines(8'h00);
        set_lines(8'h40);
        wait_irq(1'b1, 5, "retoggle_irq");
        check("retoggle_vec", irq_vector, 16'h001C);
        pulse_ack();
        set_lines(8'h00);
        pulse_done();
        rd_model(2'd2, "final_status_model");
        rd_model(2'd0, "final_pending_model");

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: sequence still running at %0t", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
